// File: rtl/hd44780_bus_pkg.sv
// Shared types and constants for the HD44780 bus sequencer: FSM states,
// Avalon register map, STATUS field layout and the queued entry format.
package hd44780_bus_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_W_AS,
    S_W_PW,
    S_W_H,
    S_W_GAP,
    S_R_AS,
    S_R_PW,
    S_R_H,
    S_R_GAP
  } state_e;

  localparam logic [1:0] REG_CMD    = 2'd0;
  localparam logic [1:0] REG_DATA   = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_OVF     = 2;
  localparam int STAT_TMO     = 3;
  localparam int STAT_AC_LSB  = 4;
  localparam int STAT_CNT_LSB = 16;

  typedef struct packed {
    logic       rs;
    logic [7:0] d;
  } fifo_entry_t;

  function automatic logic [31:0] pack_status(input logic busy, input logic full,
                                               input logic ovf, input logic tmo,
                                               input logic [6:0] ac, input logic [2:0] cnt);
    logic [31:0] s;
    s = '0;
    s[STAT_BUSY] = busy;
    s[STAT_FULL] = full;
    s[STAT_OVF]  = ovf;
    s[STAT_TMO]  = tmo;
    s[STAT_AC_LSB +: 7]  = ac;
    s[STAT_CNT_LSB +: 3] = cnt;
    return s;
  endfunction

endpackage

// File: rtl/hd44780_cmd_fifo.sv
// Four-entry queue of {rs, d} bytes waiting for the LCD bus. A push into a
// full queue is refused unless a pop frees a slot in the same cycle.
module hd44780_cmd_fifo
  import hd44780_bus_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        push,
  input  fifo_entry_t push_entry,
  input  logic        pop,
  output fifo_entry_t head,
  output logic        full,
  output logic        empty,
  output logic [2:0]  count,
  output logic        overflow
);

  logic [1:0] wr_ptr_q, wr_ptr_d;
  logic [1:0] rd_ptr_q, rd_ptr_d;
  logic [2:0] count_q, count_d;
  logic       do_push, do_pop;
  fifo_entry_t [3:0] slots;

  assign full     = (count_q == 3'd4);
  assign empty    = (count_q == 3'd0);
  assign count    = count_q;
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign overflow = push && !do_push;
  assign head     = slots[rd_ptr_q];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_slot
      fifo_entry_t slot_q, slot_d;
      always_comb begin
        slot_d = slot_q;
        if (do_push && (wr_ptr_q == 2'(gi))) slot_d = push_entry;
      end
      always_ff @(posedge clk) slot_q <= slot_d;
      assign slots[gi] = slot_q;
    end
  endgenerate

  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + 2'd1 : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + 2'd1 : rd_ptr_q;
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/hd44780_bus_ctrl.sv
// Avalon-MM slave that queues LCD instructions/data and plays them onto an
// HD44780 8-bit bus, polling the busy flag after every write access.
module hd44780_bus_ctrl
  import hd44780_bus_pkg::*;
#(
  parameter int T_AS     = 2,
  parameter int T_PW     = 24,
  parameter int T_H      = 2,
  parameter int T_GAP    = 22,
  parameter int POLL_MAX = 4095
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic        read_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  inout  wire  [7:0]  lcd_data,
  output logic        lcd_rs,
  output logic        lcd_rw,
  output logic        lcd_e
);

  localparam int T_MAX_A = (T_AS > T_PW) ? T_AS : T_PW;
  localparam int T_MAX_B = (T_H > T_GAP) ? T_H : T_GAP;
  localparam int T_MAX   = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
  localparam int CNT_W   = $clog2(T_MAX + 1);
  localparam int POLL_W  = $clog2(POLL_MAX + 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [POLL_W-1:0] poll_q, poll_d;
  logic              rs_sh_q, rs_sh_d;
  logic [7:0]        d_sh_q, d_sh_d;
  logic [7:0]        rd_q, rd_d;
  logic [6:0]        ac_q, ac_d;
  logic              ovf_q, ovf_d, tmo_q, tmo_d;
  logic [31:0]       readdata_q, readdata_d;
  logic              lcd_e_q, lcd_e_d, lcd_rs_q, lcd_rs_d, lcd_rw_q, lcd_rw_d;
  logic              bus_oe_q, bus_oe_d;

  logic        wr_en, push, stat_wr, pop, tmo_set;
  logic        fifo_full, fifo_empty, fifo_ovf;
  logic [2:0]  fifo_count;
  fifo_entry_t push_entry, head;
  logic        unused_inputs;

  assign wr_en           = chipselect && !write_n;
  assign push            = wr_en && ((address == REG_CMD) || (address == REG_DATA));
  assign stat_wr         = wr_en && (address == REG_STATUS);
  assign push_entry.rs   = (address == REG_DATA);
  assign push_entry.d    = writedata[7:0];
  assign unused_inputs   = ^{read_n, writedata[31:8]};

  hd44780_cmd_fifo u_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (fifo_count),
    .overflow   (fifo_ovf)
  );

  // Each state runs for (loaded value + 1) cycles; the counter reloads on entry.
  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q != '0) ? cnt_q - CNT_W'(1) : cnt_q;
    poll_d  = poll_q;
    rs_sh_d = rs_sh_q;
    d_sh_d  = d_sh_q;
    rd_d    = rd_q;
    ac_d    = ac_q;
    pop     = 1'b0;
    tmo_set = 1'b0;
    case (state_q)
      S_IDLE: if (!fifo_empty) begin
        pop     = 1'b1;
        rs_sh_d = head.rs;
        d_sh_d  = head.d;
        poll_d  = '0;
        state_d = S_W_AS;
        cnt_d   = CNT_W'(T_AS - 1);
      end
      S_W_AS:  if (cnt_q == '0) begin state_d = S_W_PW;  cnt_d = CNT_W'(T_PW - 1);  end
      S_W_PW:  if (cnt_q == '0) begin state_d = S_W_H;   cnt_d = CNT_W'(T_H - 1);   end
      S_W_H:   if (cnt_q == '0) begin state_d = S_W_GAP; cnt_d = CNT_W'(T_GAP - 1); end
      S_W_GAP: if (cnt_q == '0) begin
        state_d = S_R_AS;
        cnt_d   = CNT_W'(T_AS - 1);
        poll_d  = poll_q + POLL_W'(1);
      end
      S_R_AS:  if (cnt_q == '0) begin state_d = S_R_PW;  cnt_d = CNT_W'(T_PW - 1);  end
      S_R_PW:  if (cnt_q == '0) begin
        rd_d    = lcd_data;
        state_d = S_R_H;
        cnt_d   = CNT_W'(T_H - 1);
      end
      S_R_H:   if (cnt_q == '0) begin state_d = S_R_GAP; cnt_d = CNT_W'(T_GAP - 1); end
      S_R_GAP: if (cnt_q == '0) begin
        if (!rd_q[7]) begin
          ac_d    = rd_q[6:0];
          state_d = S_IDLE;
        end else if (poll_q == POLL_W'(POLL_MAX)) begin
          tmo_set = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_R_AS;
          cnt_d   = CNT_W'(T_AS - 1);
          poll_d  = poll_q + POLL_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Pin values are decoded from the next state so every pin is a flop output.
  always_comb begin
    lcd_e_d  = (state_d == S_W_PW) || (state_d == S_R_PW);
    bus_oe_d = state_d inside {S_W_AS, S_W_PW, S_W_H};
    lcd_rs_d = bus_oe_d ? rs_sh_d : 1'b0;
    lcd_rw_d = state_d inside {S_W_GAP, S_R_AS, S_R_PW, S_R_H, S_R_GAP};
    ovf_d    = fifo_ovf || (ovf_q && !(stat_wr && writedata[STAT_OVF]));
    tmo_d    = tmo_set  || (tmo_q && !(stat_wr && writedata[STAT_TMO]));
    readdata_d = (address == REG_STATUS)
               ? pack_status((state_q != S_IDLE) || !fifo_empty, fifo_full,
                             ovf_q, tmo_q, ac_q, fifo_count)
               : 32'd0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      poll_q     <= '0;
      rs_sh_q    <= 1'b0;
      d_sh_q     <= '0;
      rd_q       <= '0;
      ac_q       <= '0;
      ovf_q      <= 1'b0;
      tmo_q      <= 1'b0;
      readdata_q <= '0;
      lcd_e_q    <= 1'b0;
      lcd_rs_q   <= 1'b0;
      lcd_rw_q   <= 1'b0;
      bus_oe_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      poll_q     <= poll_d;
      rs_sh_q    <= rs_sh_d;
      d_sh_q     <= d_sh_d;
      rd_q       <= rd_d;
      ac_q       <= ac_d;
      ovf_q      <= ovf_d;
      tmo_q      <= tmo_d;
      readdata_q <= readdata_d;
      lcd_e_q    <= lcd_e_d;
      lcd_rs_q   <= lcd_rs_d;
      lcd_rw_q   <= lcd_rw_d;
      bus_oe_q   <= bus_oe_d;
    end
  end

  assign readdata = readdata_q;
  assign lcd_e    = lcd_e_q;
  assign lcd_rs   = lcd_rs_q;
  assign lcd_rw   = lcd_rw_q;
  assign lcd_data = bus_oe_q ? d_sh_q : 8'hzz;

endmodule

// File: tb/tb_hd44780_bus_ctrl.sv
// Bench for hd44780_bus_ctrl: an LCD busy-flag model, a bus monitor that
// checks every access against a queue of expected entries, and scenario tasks.
module tb_hd44780_bus_ctrl;

  localparam int T_PW = 24;

  logic        clk = 1'b0;
  logic        reset_n, cs, write_n, read_n, sel;
  logic [1:0]  address;
  logic [31:0] writedata;
  wire  [31:0] rdata0, rdata1;
  wire  [7:0]  lcd_data0, lcd_data1;
  wire         lcd_rs0, lcd_rw0, lcd_e0, lcd_rs1, lcd_rw1, lcd_e1;
  wire         cs0 = cs && !sel;
  wire         cs1 = cs && sel;

  always #10 clk = ~clk;

  hd44780_bus_ctrl dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs0),
    .write_n(write_n), .read_n(read_n), .writedata(writedata), .readdata(rdata0),
    .lcd_data(lcd_data0), .lcd_rs(lcd_rs0), .lcd_rw(lcd_rw0), .lcd_e(lcd_e0)
  );

  hd44780_bus_ctrl #(.POLL_MAX(3)) dut_p3 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs1),
    .write_n(write_n), .read_n(read_n), .writedata(writedata), .readdata(rdata1),
    .lcd_data(lcd_data1), .lcd_rs(lcd_rs1), .lcd_rw(lcd_rw1), .lcd_e(lcd_e1)
  );

  // LCD model: drives {BF, AC} while a read strobe is high.
  int         bf_left;
  logic       bf_forever;
  logic [6:0] ac_model;
  wire  [7:0] model_val = {bf_forever || (bf_left != 0), ac_model};
  assign lcd_data0 = (lcd_rw0 && lcd_e0) ? model_val : 8'hzz;
  assign lcd_data1 = (lcd_rw1 && lcd_e1) ? model_val : 8'hzz;

  wire        mon_e    = sel ? lcd_e1 : lcd_e0;
  wire        mon_rs   = sel ? lcd_rs1 : lcd_rs0;
  wire        mon_rw   = sel ? lcd_rw1 : lcd_rw0;
  wire  [7:0] mon_data = sel ? lcd_data1 : lcd_data0;
  wire        mon_oe   = sel ? dut_p3.bus_oe_q : dut.bus_oe_q;
  wire [31:0] rdata    = sel ? rdata1 : rdata0;

  int         n_checks = 0, n_fail = 0, n_wr = 0, n_rd = 0;
  logic [8:0] sb[$];
  logic       prev_e = 1'b0, prev_rw = 1'b0, rst_seen = 1'b0;
  int         width = 0;

  always @(negedge clk) begin
    logic [8:0] exp_e;
    if (!reset_n) rst_seen = 1'b1;
    n_checks++;
    if (mon_rw === 1'b1 && mon_oe === 1'b1) begin
      n_fail++; $display("FAIL contention: data driven with rw=%0b oe=%0b", mon_rw, mon_oe);
    end
    if (mon_e && prev_e) begin
      n_checks++;
      if (mon_rw !== prev_rw) begin
        n_fail++; $display("FAIL rw_during_e: rw=%0b was %0b", mon_rw, prev_rw);
      end
    end
    if (mon_e === 1'b1 && !prev_e) begin
      width = 1;
      rst_seen = 1'b0;
      n_checks++;
      if (!mon_rw) begin
        n_wr++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL unexpected_write: got %h expected none", {mon_rs, mon_data});
        end else begin
          exp_e = sb.pop_front();
          if ({mon_rs, mon_data} !== exp_e) begin
            n_fail++; $display("FAIL write_entry: got %h expected %h", {mon_rs, mon_data}, exp_e);
          end
          $display("write access rs=%0b data=%h", mon_rs, mon_data);
        end
      end else begin
        n_rd++;
        if (mon_rs !== 1'b0) begin
          n_fail++; $display("FAIL read_rs: got %0b expected 0", mon_rs);
        end
        $display("read access %0d returns %h", n_rd, model_val);
      end
    end else if (mon_e === 1'b1) begin
      width++;
    end
    if (mon_e !== 1'b1 && prev_e) begin
      if (!rst_seen) begin
        n_checks++;
        if (width != T_PW) begin
          n_fail++; $display("FAIL e_width: got %0d expected %0d", width, T_PW);
        end
      end
      if (prev_rw && bf_left > 0) bf_left--;
    end
    prev_e  = (mon_e === 1'b1);
    prev_rw = (mon_rw === 1'b1);
  end

  task automatic av_write(input logic [1:0] a, input logic [31:0] wd);
    cs = 1'b1; write_n = 1'b0; address = a; writedata = wd;
    @(posedge clk); #1;
    cs = 1'b0; write_n = 1'b1;
  endtask

  task automatic av_read(input logic [1:0] a, output logic [31:0] v);
    cs = 1'b1; read_n = 1'b0; address = a;
    @(posedge clk); #1;
    v = rdata;
    cs = 1'b0; read_n = 1'b1;
  endtask

  task automatic wait_idle(input int max_cycles, output int cycles, output logic [31:0] s);
    cycles = 0;
    do begin
      av_read(2'd2, s);
      cycles++;
    end while (s[0] && cycles < max_cycles);
    n_checks++;
    if (s[0] !== 1'b0) begin
      n_fail++; $display("FAIL idle_timeout: busy=%0b after %0d cycles expected 0", s[0], cycles);
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
    end
  endtask

  task automatic test_reset;
    logic [31:0] s;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({lcd_e0, lcd_rs0, lcd_rw0, dut.bus_oe_q} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_pins: got e/rs/rw/oe=%b expected 0000",
                         {lcd_e0, lcd_rs0, lcd_rw0, dut.bus_oe_q});
    end
    n_checks++;
    if (rdata0 !== 32'd0 || rdata1 !== 32'd0) begin
      n_fail++; $display("FAIL reset_readdata: got %h/%h expected 0", rdata0, rdata1);
    end
    reset_n = 1'b1;
    av_read(2'd2, s);
    n_checks++;
    if (s !== 32'd0) begin
      n_fail++; $display("FAIL reset_status: got %h expected 0", s);
    end
    $display("reset: status=%h", s);
  endtask

  task automatic test_single_cmd;
    logic [31:0] s;
    int n, cyc, w0, r0;
    w0 = n_wr; r0 = n_rd;
    ac_model = 7'h12; bf_left = 0;
    sb.push_back({1'b0, 8'h38});
    av_write(2'd0, 32'h38);
    n = 0;
    while (mon_e !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    n_checks++;
    if (n != 3) begin
      n_fail++; $display("FAIL e_latency: got %0d cycles expected 3", n);
    end
    wait_idle(300, cyc, s);
    n_checks++;
    if (n + cyc != 102) begin
      n_fail++; $display("FAIL busy_duration: got %0d cycles expected 102", n + cyc);
    end
    n_checks++;
    if (n_wr - w0 != 1 || n_rd - r0 != 1) begin
      n_fail++; $display("FAIL single_accesses: got %0d wr %0d rd expected 1 1", n_wr - w0, n_rd - r0);
    end
    n_checks++;
    if (s[10:4] !== 7'h12) begin
      n_fail++; $display("FAIL single_ac: got %h expected 12", s[10:4]);
    end
    $display("single cmd: status=%h cycles=%0d", s, n + cyc);
  endtask

  task automatic test_back_to_back;
    logic [31:0] s;
    int cyc, w0;
    w0 = n_wr;
    for (int i = 0; i < 5; i++) begin
      sb.push_back({1'b1, 8'h41 + 8'(i)});
      av_write(2'd1, 32'h41 + i);
    end
    av_read(2'd2, s);
    n_checks++;
    if (s[18:16] !== 3'd4 || s[1] !== 1'b1 || s[2] !== 1'b0) begin
      n_fail++; $display("FAIL b2b_status: got cnt=%0d full=%0b ovf=%0b expected 4 1 0", s[18:16], s[1], s[2]);
    end
    av_read(2'd1, s);
    n_checks++;
    if (s !== 32'd0) begin
      n_fail++; $display("FAIL data_read: got %h expected 0", s);
    end
    wait_idle(800, cyc, s);
    n_checks++;
    if (n_wr - w0 != 5 || s[2] !== 1'b0) begin
      n_fail++; $display("FAIL b2b_done: got %0d writes ovf=%0b expected 5 0", n_wr - w0, s[2]);
    end
    $display("back to back: status=%h", s);
  endtask

  task automatic test_overflow;
    logic [31:0] s;
    int cyc, w0;
    w0 = n_wr;
    for (int i = 0; i < 6; i++) begin
      if (i < 5) sb.push_back({1'b1, 8'h50 + 8'(i)});
      av_write(2'd1, 32'h50 + i);
    end
    av_read(2'd2, s);
    n_checks++;
    if (s[2] !== 1'b1 || s[18:16] !== 3'd4) begin
      n_fail++; $display("FAIL ovf_set: got ovf=%0b cnt=%0d expected 1 4", s[2], s[18:16]);
    end
    av_write(2'd2, 32'h4);
    av_read(2'd2, s);
    n_checks++;
    if (s[2] !== 1'b0) begin
      n_fail++; $display("FAIL ovf_clear: got %0b expected 0", s[2]);
    end
    wait_idle(800, cyc, s);
    n_checks++;
    if (n_wr - w0 != 5) begin
      n_fail++; $display("FAIL ovf_writes: got %0d expected 5", n_wr - w0);
    end
    $display("overflow: status=%h", s);
  endtask

  task automatic test_busy_poll;
    logic [31:0] s;
    int cyc, r0;
    r0 = n_rd;
    bf_left = 3; ac_model = 7'h05;
    sb.push_back({1'b0, 8'h01});
    av_write(2'd0, 32'h01);
    wait_idle(600, cyc, s);
    n_checks++;
    if (n_rd - r0 != 4) begin
      n_fail++; $display("FAIL poll_reads: got %0d expected 4", n_rd - r0);
    end
    n_checks++;
    if (s[10:4] !== 7'h05 || s[3] !== 1'b0) begin
      n_fail++; $display("FAIL poll_ac: got ac=%h tmo=%0b expected 05 0", s[10:4], s[3]);
    end
    $display("busy poll: status=%h", s);
  endtask

  task automatic test_timeout;
    logic [31:0] s;
    int cyc, w0, r0;
    sel = 1'b1;
    w0 = n_wr; r0 = n_rd;
    bf_forever = 1'b1; ac_model = 7'h55;
    sb.push_back({1'b0, 8'h02});
    sb.push_back({1'b1, 8'h43});
    av_write(2'd0, 32'h02);
    av_write(2'd1, 32'h43);
    wait_idle(1000, cyc, s);
    n_checks++;
    if (n_wr - w0 != 2 || n_rd - r0 != 6) begin
      n_fail++; $display("FAIL tmo_accesses: got %0d wr %0d rd expected 2 6", n_wr - w0, n_rd - r0);
    end
    n_checks++;
    if (s[3] !== 1'b1 || s[10:4] !== 7'h00) begin
      n_fail++; $display("FAIL tmo_set: got tmo=%0b ac=%h expected 1 00", s[3], s[10:4]);
    end
    av_write(2'd2, 32'h8);
    av_read(2'd2, s);
    n_checks++;
    if (s[3] !== 1'b0) begin
      n_fail++; $display("FAIL tmo_clear: got %0b expected 0", s[3]);
    end
    $display("timeout: status=%h", s);
    bf_forever = 1'b0;
    sel = 1'b0;
  endtask

  task automatic test_reset_mid;
    logic [31:0] s;
    int n, w0, r0;
    bf_left = 0;
    for (int i = 0; i < 3; i++) begin
      sb.push_back({1'b1, 8'h60 + 8'(i)});
      av_write(2'd1, 32'h60 + i);
    end
    n = 0;
    while (mon_e !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    repeat (4) begin @(posedge clk); #1; end
    av_read(2'd2, s);
    n_checks++;
    if (s[18:16] !== 3'd2 || lcd_e0 !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset: got cnt=%0d e=%0b expected 2 1", s[18:16], lcd_e0);
    end
    reset_n = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if ({lcd_e0, lcd_rs0, lcd_rw0, dut.bus_oe_q} !== 4'b0000 || rdata0 !== 32'd0) begin
      n_fail++; $display("FAIL mid_reset_pins: got e/rs/rw/oe=%b rd=%h expected 0000 0",
                         {lcd_e0, lcd_rs0, lcd_rw0, dut.bus_oe_q}, rdata0);
    end
    reset_n = 1'b1;
    sb.delete();
    w0 = n_wr; r0 = n_rd;
    av_read(2'd2, s);
    n_checks++;
    if (s !== 32'd0) begin
      n_fail++; $display("FAIL mid_reset_status: got %h expected 0", s);
    end
    repeat (300) @(posedge clk);
    #1;
    n_checks++;
    if (n_wr != w0 || n_rd != r0) begin
      n_fail++; $display("FAIL post_reset_quiet: got %0d wr %0d rd expected 0 0", n_wr - w0, n_rd - r0);
    end
    $display("reset mid access: status=%h", s);
  endtask

  initial begin
    reset_n = 1'b0; cs = 1'b0; write_n = 1'b1; read_n = 1'b1; sel = 1'b0;
    address = 2'd0; writedata = 32'd0;
    bf_left = 0; bf_forever = 1'b0; ac_model = 7'h00;
    @(posedge clk); #1;
    test_reset;
    test_single_cmd;
    test_back_to_back;
    test_overflow;
    test_busy_poll;
    test_timeout;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #(20 * 50000);
    $display("FAIL watchdog: simulation exceeded 50000 cycles");
    $fatal(1);
  end

endmodule
